// File: rtl/rename_pkg.sv
// Shared rename/retire types: register index widths and the reorder-buffer entry.
package rename_pkg;
  localparam int ARCH_W = 5;
  localparam int PHY_W  = 6;
  localparam int LANES  = 4;
  localparam int CNT_W  = 3;  // holds 0..LANES

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispredict;
    logic              regw;
    logic [ARCH_W-1:0] rdst;
    logic [PHY_W-1:0]  phy;
  } rob_entry_t;
endpackage

// File: rtl/lane_alloc.sv
// Dispatch-lane prefix popcount: slot offset of each valid lane and total allocated.
module lane_alloc
  import rename_pkg::*;
(
  input  logic [LANES-1:0]            valid,
  output logic [LANES-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]            total
);
  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(valid[i]);
    end
    total = acc;
  end
endmodule

// File: rtl/commit_unit.sv
// In-order retirement buffer: 4-wide allocate, two writeback ports, single retire per cycle.
// PHY_W/ARCH_W must match the rename_pkg widths used by rob_entry_t.
module commit_unit #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PHY_W  = 6,
  parameter int ARCH_W = 5
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          Disp_Valid,
  input  logic [3:0]          Disp_RegW,
  input  logic [4*ARCH_W-1:0] Disp_Rdst,
  input  logic [4*PHY_W-1:0]  Disp_Phy,
  output logic                Disp_Ready,
  output logic [4*IDX_W-1:0]  Disp_Tag,
  input  logic                WB0_Valid,
  input  logic [IDX_W-1:0]    WB0_Tag,
  input  logic                WB0_Mispredict,
  input  logic                WB1_Valid,
  input  logic [IDX_W-1:0]    WB1_Tag,
  input  logic                WB1_Mispredict,
  output logic                Commit,
  output logic [PHY_W-1:0]    Commit_Phy,
  output logic [ARCH_W-1:0]   Commit_Rdst,
  output logic                Branch_flush,
  output logic                Empty,
  output logic [IDX_W:0]      Count
);
  import rename_pkg::*;

  rob_entry_t [DEPTH-1:0]           rob, rob_nx;
  logic [IDX_W-1:0]                 head, tail;
  logic [IDX_W:0]                   count;
  logic [LANES-1:0][CNT_W-1:0]      lane_off;
  logic [LANES-1:0][IDX_W-1:0]      tag;
  logic [CNT_W-1:0]                 alloc_total, alloc_n;
  rob_entry_t                       head_e;
  logic                             retire, flush_now;

  lane_alloc u_alloc (
    .valid  (Disp_Valid),
    .offset (lane_off),
    .total  (alloc_total)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_tag
    assign tag[i] = tail + IDX_W'(lane_off[i]);
  end
  assign Disp_Tag = tag;

  // Capacity check ignores a same-cycle retire so the ready path stays short.
  assign Disp_Ready = (count <= (IDX_W+1)'(DEPTH - LANES)) && !Branch_flush;
  assign alloc_n    = Disp_Ready ? alloc_total : '0;

  assign head_e    = rob[head];
  assign retire    = head_e.valid && head_e.done && !Branch_flush;
  assign flush_now = retire && head_e.mispredict;

  assign Empty = (count == '0);
  assign Count = count;

  always_comb begin
    rob_nx = rob;
    if (WB0_Valid && rob[WB0_Tag].valid) begin
      rob_nx[WB0_Tag].done       = 1'b1;
      rob_nx[WB0_Tag].mispredict = rob_nx[WB0_Tag].mispredict | WB0_Mispredict;
    end
    if (WB1_Valid && rob[WB1_Tag].valid) begin
      rob_nx[WB1_Tag].done       = 1'b1;
      rob_nx[WB1_Tag].mispredict = rob_nx[WB1_Tag].mispredict | WB1_Mispredict;
    end
    for (int i = 0; i < LANES; i++) begin
      if (Disp_Ready && Disp_Valid[i]) begin
        rob_nx[tag[i]].valid      = 1'b1;
        rob_nx[tag[i]].done       = 1'b0;
        rob_nx[tag[i]].mispredict = 1'b0;
        rob_nx[tag[i]].regw       = Disp_RegW[i];
        rob_nx[tag[i]].rdst       = Disp_Rdst[i*ARCH_W +: ARCH_W];
        rob_nx[tag[i]].phy        = Disp_Phy[i*PHY_W +: PHY_W];
      end
    end
    if (retire) rob_nx[head] = '0;
    // A mispredicted retire squashes everything, including this cycle's dispatch and writebacks.
    if (flush_now) rob_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      Commit       <= 1'b0;
      Commit_Phy   <= '0;
      Commit_Rdst  <= '0;
      Branch_flush <= 1'b0;
    end else begin
      rob          <= rob_nx;
      Commit       <= retire && head_e.regw;
      Branch_flush <= flush_now;
      if (retire) begin
        Commit_Phy  <= head_e.phy;
        Commit_Rdst <= head_e.rdst;
      end
      if (flush_now) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (retire) head <= head + IDX_W'(1);
        tail  <= tail + IDX_W'(alloc_n);
        count <= count + (IDX_W+1)'(alloc_n) - (IDX_W+1)'(retire);
      end
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: queue-based reference model plus hand-computed checkpoints.
module tb_commit_unit;
  localparam int DEPTH = 16;

  logic        clk, rst;
  logic [3:0]  Disp_Valid, Disp_RegW;
  logic [19:0] Disp_Rdst;
  logic [23:0] Disp_Phy;
  logic        Disp_Ready;
  logic [15:0] Disp_Tag;
  logic        WB0_Valid, WB0_Mispredict, WB1_Valid, WB1_Mispredict;
  logic [3:0]  WB0_Tag, WB1_Tag;
  logic        Commit, Branch_flush, Empty;
  logic [5:0]  Commit_Phy;
  logic [4:0]  Commit_Rdst;
  logic [4:0]  Count;

  commit_unit dut (
    .clk(clk), .rst(rst),
    .Disp_Valid(Disp_Valid), .Disp_RegW(Disp_RegW), .Disp_Rdst(Disp_Rdst), .Disp_Phy(Disp_Phy),
    .Disp_Ready(Disp_Ready), .Disp_Tag(Disp_Tag),
    .WB0_Valid(WB0_Valid), .WB0_Tag(WB0_Tag), .WB0_Mispredict(WB0_Mispredict),
    .WB1_Valid(WB1_Valid), .WB1_Tag(WB1_Tag), .WB1_Mispredict(WB1_Mispredict),
    .Commit(Commit), .Commit_Phy(Commit_Phy), .Commit_Rdst(Commit_Rdst),
    .Branch_flush(Branch_flush), .Empty(Empty), .Count(Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in program order, oldest first.
  typedef struct {
    int tag; bit regw; int rdst; int phy; bit done; bit misp;
  } ment_t;
  ment_t mq[$];
  int m_tail = 0, m_phy = 0, m_rdst = 0;
  bit m_flush = 0, m_commit = 0;

  function automatic bit m_ready();
    return !m_flush && (DEPTH - mq.size()) >= 4;
  endfunction

  task automatic model_step();
    bit    ret;
    ment_t h, e;
    int    n;
    if (rst) begin
      mq.delete(); m_tail = 0; m_commit = 0; m_phy = 0; m_rdst = 0; m_flush = 0;
      return;
    end
    ret = !m_flush && mq.size() > 0 && mq[0].done;
    if (ret) h = mq[0];
    foreach (mq[k]) begin
      if (WB0_Valid && mq[k].tag == int'(WB0_Tag)) begin mq[k].done = 1; mq[k].misp |= WB0_Mispredict; end
      if (WB1_Valid && mq[k].tag == int'(WB1_Tag)) begin mq[k].done = 1; mq[k].misp |= WB1_Mispredict; end
    end
    if (m_ready()) begin
      n = 0;
      for (int i = 0; i < 4; i++) if (Disp_Valid[i]) begin
        e.tag = (m_tail + n) % DEPTH; e.regw = Disp_RegW[i];
        e.rdst = int'(Disp_Rdst[i*5 +: 5]); e.phy = int'(Disp_Phy[i*6 +: 6]);
        e.done = 0; e.misp = 0;
        mq.push_back(e);
        n++;
      end
      m_tail = (m_tail + n) % DEPTH;
    end
    if (ret) begin
      void'(mq.pop_front());
      m_phy = h.phy; m_rdst = h.rdst;
    end
    m_commit = ret && h.regw;
    m_flush  = ret && h.misp;
    if (m_flush) begin mq.delete(); m_tail = 0; end
  endtask

  // One clock: check combinational dispatch outputs, advance model, check registered outputs.
  task automatic tick();
    int n;
    #1;
    if (!rst) begin
      chk("disp_ready", Disp_Ready, m_ready());
      n = 0;
      for (int i = 0; i < 4; i++) if (Disp_Valid[i]) begin
        chk("disp_tag", int'(Disp_Tag[i*4 +: 4]), (m_tail + n) % DEPTH);
        n++;
      end
    end
    model_step();
    @(posedge clk);
    #1;
    chk("commit", Commit, m_commit);
    chk("commit_phy", Commit_Phy, m_phy);
    chk("commit_rdst", Commit_Rdst, m_rdst);
    chk("branch_flush", Branch_flush, m_flush);
    chk("count", Count, mq.size());
    chk("empty", Empty, mq.size() == 0);
    chk("ready_after", Disp_Ready, m_ready());
  endtask

  task automatic idle();
    Disp_Valid = '0; Disp_RegW = '0; Disp_Rdst = '0; Disp_Phy = '0;
    WB0_Valid = 0; WB0_Tag = '0; WB0_Mispredict = 0;
    WB1_Valid = 0; WB1_Tag = '0; WB1_Mispredict = 0;
  endtask

  task automatic set_lane(input int i, input bit w, input int rd, input int ph);
    Disp_Valid[i] = 1'b1;
    Disp_RegW[i]  = w;
    Disp_Rdst[i*5 +: 5] = 5'(rd);
    Disp_Phy[i*6 +: 6]  = 6'(ph);
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick(); rst = 0;
    chk("rst_count", Count, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_ready", Disp_Ready, 1);
    chk("rst_commit", Commit, 0);

    // Four-wide dispatch, out-of-order completion, in-order retire.
    for (int i = 0; i < 4; i++) set_lane(i, 1, i + 1, 32 + i);
    #1 chk("tags_0123", Disp_Tag, 16'h3210);
    tick(); idle();
    chk("count4", Count, 4);
    for (int t = 3; t >= 0; t--) begin
      WB0_Valid = 1; WB0_Tag = 4'(t);
      tick();
      chk("no_commit_yet", Commit, 0);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("inorder_commit", Commit, 1);
      chk("inorder_rdst", Commit_Rdst, k + 1);
      chk("inorder_phy", Commit_Phy, 32 + k);
    end

    // Sparse lanes; regw=0 entry retires silently.
    do_reset();
    set_lane(1, 0, 7, 40); set_lane(3, 1, 8, 41);
    Disp_Valid = 4'b1010;
    #1 chk("sparse_tag_l1", Disp_Tag[7:4], 0);
    chk("sparse_tag_l3", Disp_Tag[15:12], 1);
    tick(); idle();
    chk("sparse_count", Count, 2);
    WB0_Valid = 1; WB0_Tag = 4'd0; tick(); idle(); tick();
    chk("regw0_commit", Commit, 0);
    chk("regw0_count", Count, 1);
    WB0_Valid = 1; WB0_Tag = 4'd1; tick(); idle(); tick();
    chk("regw1_commit", Commit, 1);
    chk("regw1_rdst", Commit_Rdst, 8);

    // Fill to 13 and stall.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 1, r * 4 + i, r * 4 + i);
      if (r == 0) #1 chk("fill_first_tag", Disp_Tag[3:0], 2);
      tick();
    end
    idle(); set_lane(0, 1, 20, 20); tick();
    chk("count13", Count, 13);
    for (int i = 0; i < 4; i++) set_lane(i, 1, 21 + i, 21 + i);
    #1 chk("full_ready", Disp_Ready, 0);
    tick();
    chk("count13_hold", Count, 13);
    WB0_Valid = 1; WB0_Tag = 4'd2; tick();
    WB0_Valid = 0; tick();
    chk("count12", Count, 12);
    chk("ready12", Disp_Ready, 1);
    idle();

    // Wrap-around with concurrent allocate and retire.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle();
      set_lane(0, 1, i % 32, i);
      if (i > 0) begin WB0_Valid = 1; WB0_Tag = 4'((i - 1) % 16); end
      if (i == 15) #1 chk("wrap_tag15", Disp_Tag[3:0], 15);
      if (i == 16) #1 chk("wrap_tag0", Disp_Tag[3:0], 0);
      tick();
      if (i == 10) chk("wrap_count", Count, 2);
      if (i == 17) begin chk("wrap_c15", Commit, 1); chk("wrap_phy15", Commit_Phy, 15); end
      if (i == 18) begin chk("wrap_c0", Commit, 1); chk("wrap_phy16", Commit_Phy, 16); end
    end
    idle(); WB0_Valid = 1; WB0_Tag = 4'd3; tick();
    idle(); tick(); tick();
    chk("wrap_drained", Count, 0);

    // Mispredict flush.
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 1, 10 + i, 20 + i);
    tick(); idle();
    set_lane(0, 1, 14, 24); set_lane(1, 1, 15, 25);
    tick(); idle();
    WB0_Valid = 1; WB0_Tag = 4'd0; WB1_Valid = 1; WB1_Tag = 4'd1; tick();
    WB0_Tag = 4'd3; WB1_Tag = 4'd4; tick();
    WB0_Tag = 4'd5; WB1_Valid = 0; tick();
    WB0_Tag = 4'd2; WB0_Mispredict = 0; WB1_Valid = 1; WB1_Tag = 4'd2; WB1_Mispredict = 1; tick();
    idle();
    for (int i = 0; i < 4; i++) set_lane(i, 1, 1, 1);
    tick();
    chk("flush_commit", Commit, 1);
    chk("flush_rdst", Commit_Rdst, 12);
    chk("flush_phy", Commit_Phy, 22);
    chk("flush_pulse", Branch_flush, 1);
    chk("flush_count", Count, 0);
    chk("flush_empty", Empty, 1);
    chk("flush_ready", Disp_Ready, 0);
    tick();
    chk("flush_one_cycle", Branch_flush, 0);
    chk("flush_no_alloc", Count, 0);
    idle();
    for (int k = 0; k < 3; k++) begin tick(); chk("squashed_no_commit", Commit, 0); end

    // Stray writeback, then reset overriding a pending retire.
    do_reset();
    WB0_Valid = 1; WB0_Tag = 4'd0; tick(); idle();
    for (int i = 0; i < 4; i++) set_lane(i, 1, 1 + i, 1 + i);
    tick(); idle();
    set_lane(0, 1, 5, 5); set_lane(1, 1, 6, 6); tick(); idle();
    chk("count6", Count, 6);
    tick();
    chk("stray_wb_ignored", Commit, 0);
    WB0_Valid = 1; WB0_Tag = 4'd0; tick(); idle();
    rst = 1; tick(); rst = 0;
    chk("rst_mid_commit", Commit, 0);
    chk("rst_mid_count", Count, 0);
    chk("rst_mid_empty", Empty, 1);
    chk("rst_mid_ready", Disp_Ready, 1);
    tick();
    chk("rst_mid_after", Commit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement buffer (reorder buffer) that sits between dispatch/execute and the register-rename stage.
- Accepts up to 4 renamed instructions per cycle and records completion from two writeback ports.
- Retires at most one instruction per cycle from the head, driving the rename stage's Commit/Commit_Phy/Commit_Rdst inputs and its Branch_flush input.

Parameters:
- DEPTH, 16: number of entries; power of 2, at least 8.
- IDX_W, 4: tag width; equals log2(DEPTH).
- PHY_W, 6: physical register index width.
- ARCH_W, 5: architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- Disp_Valid  in  4  per-lane dispatch valid; lane 0 is oldest.
- Disp_RegW  in  4  per-lane "writes a destination register".
- Disp_Rdst  in  4*ARCH_W  per-lane architectural destination; lane i at bits [i*ARCH_W +: ARCH_W].
- Disp_Phy  in  4*PHY_W  per-lane physical destination.
- Disp_Ready  out  1  dispatch accepted this cycle.
- Disp_Tag  out  4*IDX_W  per-lane allocated tag (combinational).
- WB0_Valid, WB1_Valid  in  1  writeback valid.
- WB0_Tag, WB1_Tag  in  IDX_W  completing entry.
- WB0_Mispredict, WB1_Mispredict  in  1  entry is a mispredicted branch.
- Commit  out  1  retiring entry writes a register.
- Commit_Phy  out  PHY_W  physical register of the retiring entry.
- Commit_Rdst  out  ARCH_W  architectural register of the retiring entry.
- Branch_flush  out  1  pipeline flush pulse.
- Empty  out  1  count == 0.
- Count  out  IDX_W+1  number of occupied entries.

Behaviour:
- Storage:
  - Per entry: valid, done, mispredict, regw, rdst, phy.
  - Pointers: head and tail, IDX_W bits each, wrapping modulo DEPTH.
  - Count register, IDX_W+1 bits.
- Reset (synchronous): all entries invalid; head = tail = 0; Count = 0.
  - Registered outputs reset to: Commit = 0, Commit_Phy = 0, Commit_Rdst = 0, Branch_flush = 0.
  - Empty = 1 and Disp_Ready = 1 follow from Count = 0.
  - Reset overrides dispatch, writeback and retire in the same cycle.
- Dispatch:
  - Disp_Ready = (DEPTH - Count >= 4) & ~Branch_flush. It does not credit a same-cycle retire.
  - When Disp_Ready = 1, each lane with Disp_Valid set is allocated in lane order. Invalid lanes are skipped and do not consume a slot.
  - Disp_Tag[i] = tail + (number of valid lanes below i), modulo DEPTH.
  - Allocated entries are set valid=1, done=0, mispredict=0, with regw/rdst/phy from the lane.
  - tail advances by popcount(Disp_Valid).
  - When Disp_Ready = 0, nothing is written. The upstream stage holds its lanes.
- Writeback:
  - A WBx_Valid targeting a valid entry sets done=1 and mispredict |= WBx_Mispredict.
  - A writeback to an invalid entry is ignored.
  - WB0 and WB1 to the same tag: done is set and the mispredict bits are ORed.
  - A writeback to the head entry in cycle N makes it eligible to retire in cycle N+1.
- Retire:
  - When the head entry is valid and done in cycle N, it retires in cycle N.
  - Effects at cycle N: the entry is cleared, head increments, and Count decrements.
  - Registered at the N+1 edge: Commit = regw, Commit_Rdst = rdst, Commit_Phy = phy.
  - Commit_Rdst = 0 with regw = 1 is still reported; the rename stage filters r0.
  - When no entry retires, Commit = 0 and Commit_Phy/Commit_Rdst hold their last values.
- Flush:
  - If the retiring head has mispredict=1, Branch_flush = 1 in the same cycle as its Commit output.
  - At the same edge, all entries are invalidated, head = tail = 0 and Count = 0.
  - Dispatch and writeback in the retiring cycle are discarded.
  - While Branch_flush is high, Disp_Ready = 0 and nothing retires.
  - Branch_flush lasts exactly one cycle.
- Count update: next Count = Count + allocated - retired. Simultaneous allocate and retire is legal.
  - Full: Count == DEPTH. At DEPTH-3 or above, Disp_Ready = 0.
  - Pointer wrap-around is transparent to tags.

Decomposition:
- Shared package rename_pkg:
  - ARCH_W and PHY_W constants.
  - rob_entry_t struct {valid, done, mispredict, regw, rdst, phy}.
- One sub-module: lane_alloc. It is combinational: a 4-lane prefix popcount that produces the per-lane tag offsets and the total allocated count.

Test Plan:
- Reset, then Disp_Valid=4'b1111 (RegW all 1, Rdst 1..4, Phy 32..35):
  - Disp_Tag = 0,1,2,3 and Count = 4.
  - Writeback tags 3,2,1,0, one per cycle: no Commit until tag 0 is done.
  - Then Commit pulses on 4 consecutive cycles with (Rdst, Phy) = (1,32), (2,33), (3,34), (4,35).
- Disp_Valid=4'b1010:
  - Tags 0 (lane 1) and 1 (lane 3); tail = 2.
  - An entry with RegW=0 retires with Commit = 0 and Count decrements.
- Fill to Count = 13:
  - Disp_Ready = 0 and no allocation; Count stays 13.
  - Retire one entry: Count = 12, Disp_Ready = 1.
- Wrap-around:
  - After 20 dispatch/retire pairs, a tag-15 entry followed by a tag-0 entry retire in order.
  - Count is correct throughout.
- Entry tag 2 completes with WB1_Mispredict=1; tags 3-5 are done:
  - Commit for tag 2 and Branch_flush pulse in the same cycle.
  - Next cycle: Count = 0, Empty = 1, and tags 3-5 are never committed.
  - A dispatch presented in the flush cycle is not allocated.
- rst asserted with Count = 6 and a head entry ready to retire:
  - Next cycle: Commit = 0, Count = 0, Empty = 1, Disp_Ready = 1.
